// File: rtl/exec_pkg.sv
// Action opcodes, slot layout and sizes shared by the executor and its ALU.
package exec_pkg;
`include "def.svh"

  localparam int BYTE_W     = `BYTE_BUS;
  localparam int DATA_W     = `DATA_BUS;
  localparam int VAL_LEN    = `MAX_VAL_LEN;
  localparam int HDR_LEN    = `HDR_MAX_LEN;
  localparam int NUM_HDRS   = `NUM_HEADERS;
  localparam int SLOT_BYTES = 4;
  localparam int HID_W      = 4;

  typedef enum logic [BYTE_W-1:0] {
    OP_END  = 8'd0,
    OP_SET  = 8'd1,
    OP_ADD  = 8'd2,
    OP_DROP = 8'd3,
    OP_FWD  = 8'd4
  } opcode_e;

  typedef struct packed {
    logic [BYTE_W-1:0] opcode;
    logic [HID_W-1:0]  hdr_id;
    logic [BYTE_W-1:0] off;
    logic [BYTE_W-1:0] arg;
  } slot_t;
endpackage

// File: rtl/action_alu.sv
// Decodes one action slot against its target header byte; purely combinational.
// ADD support is built only when EXECUTOR_ADD_EN is defined.
module action_alu
  import exec_pkg::*;
(
  input  logic [BYTE_W-1:0] op_i,
  input  logic [BYTE_W-1:0] arg_i,
  input  logic [DATA_W-1:0] idx_i,
`ifdef EXECUTOR_ADD_EN
  input  logic [BYTE_W-1:0] byte_i,
`endif
  output logic              wr_o,
  output logic [BYTE_W-1:0] byte_o,
  output logic              drop_o,
  output logic              fwd_o,
  output logic [BYTE_W-1:0] port_o,
  output logic              err_o,
  output logic              end_o
);
  logic in_range;

  assign in_range = idx_i < DATA_W'(HDR_LEN);
  assign port_o   = arg_i;

  always_comb begin
    wr_o   = 1'b0;
    byte_o = arg_i;
    drop_o = 1'b0;
    fwd_o  = 1'b0;
    err_o  = 1'b0;
    end_o  = 1'b0;
    case (op_i)
      OP_END: end_o = 1'b1;
      OP_SET: begin
        wr_o  = in_range;
        err_o = !in_range;
      end
`ifdef EXECUTOR_ADD_EN
      OP_ADD: begin
        wr_o   = in_range;
        err_o  = !in_range;
        byte_o = byte_i + arg_i;
      end
`endif
      OP_DROP: drop_o = 1'b1;
      OP_FWD:  fwd_o  = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/def.svh
// Shared bus and table sizing for the match-action pipeline.
`ifndef EXEC_DEF_SVH
`define EXEC_DEF_SVH
`define BYTE_BUS    8
`define DATA_BUS    32
`define MAX_VAL_LEN 16
`define HDR_MAX_LEN 32
`define NUM_HEADERS 16
`endif

// File: rtl/executor.sv
// Applies a matched flow's action list to a packet header, one slot per cycle.
// ADD action is compiled in only when EXECUTOR_ADD_EN is defined.
module executor
  import exec_pkg::*;
#(
  parameter int NUM_ACTIONS = VAL_LEN / 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_i,
  input  logic                                is_match_i,
  input  logic [VAL_LEN-1:0][BYTE_W-1:0]      flow_val_i,
  input  logic [HDR_LEN-1:0][BYTE_W-1:0]      pkt_hdr_i,
  input  logic [NUM_HDRS-1:0][DATA_W-1:0]     parsed_hdrs_i,
  input  logic                                mod_start_i,
  input  logic [7:0]                          mod_default_port_i,
  input  logic                                mod_default_drop_i,
  output logic                                ready_o,
  output logic [HDR_LEN-1:0][BYTE_W-1:0]      pkt_hdr_o,
  output logic [7:0]                          port_o,
  output logic                                drop_o,
  output logic                                err_o
);
  localparam int SLOTW = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1;
  localparam int HIDXW = $clog2(HDR_LEN);
  localparam logic [SLOTW-1:0] LAST_SLOT = SLOTW'(NUM_ACTIONS - 1);

  typedef enum logic [1:0] {FREE, EXEC, DONE} state_e;

  state_e                                       state_q, state_d;
  logic [SLOTW-1:0]                             slot_q, slot_d;
  logic                                         match_q, match_d;
  logic [NUM_ACTIONS-1:0][SLOT_BYTES-1:0][BYTE_W-1:0] flow_q, flow_d;
  logic [HDR_LEN-1:0][BYTE_W-1:0]               work_q, work_d;
  logic [HDR_LEN-1:0][BYTE_W-1:0]               hdr_q, hdr_d;
  logic [7:0]                                   port_q, port_d, def_port_q, def_port_d;
  logic                                         drop_q, drop_d, def_drop_q, def_drop_d;
  logic                                         err_q, err_d, rdy_q, rdy_d;

  slot_t             cur;
  logic [DATA_W-1:0] idx;
  logic              alu_wr, alu_drop, alu_fwd, alu_err, alu_end;
  logic [BYTE_W-1:0] alu_byte, alu_port;

  always_comb begin
    cur.opcode = flow_q[slot_q][0];
    cur.hdr_id = flow_q[slot_q][1][HID_W-1:0];
    cur.off    = flow_q[slot_q][2];
    cur.arg    = flow_q[slot_q][3];
  end

  // Target offset wraps at 32 bits; the ALU flags anything past the header.
  assign idx = parsed_hdrs_i[cur.hdr_id] + DATA_W'(cur.off);

  action_alu u_alu (
    .op_i   (cur.opcode),
    .arg_i  (cur.arg),
    .idx_i  (idx),
`ifdef EXECUTOR_ADD_EN
    .byte_i (work_q[idx[HIDXW-1:0]]),
`endif
    .wr_o   (alu_wr),
    .byte_o (alu_byte),
    .drop_o (alu_drop),
    .fwd_o  (alu_fwd),
    .port_o (alu_port),
    .err_o  (alu_err),
    .end_o  (alu_end)
  );

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    match_d    = match_q;
    flow_d     = flow_q;
    work_d     = work_q;
    hdr_d      = hdr_q;
    port_d     = port_q;
    drop_d     = drop_q;
    err_d      = err_q;
    rdy_d      = rdy_q;
    def_port_d = def_port_q;
    def_drop_d = def_drop_q;
    case (state_q)
      FREE: begin
        if (mod_start_i) begin
          def_port_d = mod_default_port_i;
          def_drop_d = mod_default_drop_i;
        end else if (start_i) begin
          state_d = EXEC;
          flow_d  = flow_val_i;
          match_d = is_match_i;
          work_d  = pkt_hdr_i;
          rdy_d   = 1'b0;
          drop_d  = 1'b0;
          err_d   = 1'b0;
          port_d  = def_port_q;
          slot_d  = '0;
        end
      end
      EXEC: begin
        if (!match_q) begin
          drop_d  = def_drop_q;
          hdr_d   = work_q;
          rdy_d   = 1'b1;
          state_d = DONE;
        end else begin
          if (alu_wr)   work_d[idx[HIDXW-1:0]] = alu_byte;
          if (alu_err)  err_d  = 1'b1;
          if (alu_drop) drop_d = 1'b1;
          if (alu_fwd)  port_d = alu_port;
          if (alu_end || slot_q == LAST_SLOT) begin
            hdr_d   = work_d;
            rdy_d   = 1'b1;
            state_d = DONE;
          end else begin
            slot_d = slot_q + SLOTW'(1);
          end
        end
      end
      DONE: if (!start_i) state_d = FREE;
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FREE;
      slot_q     <= '0;
      match_q    <= 1'b0;
      flow_q     <= '0;
      work_q     <= '0;
      hdr_q      <= '0;
      port_q     <= '0;
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b0;
      def_port_q <= '0;
      def_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      match_q    <= match_d;
      flow_q     <= flow_d;
      work_q     <= work_d;
      hdr_q      <= hdr_d;
      port_q     <= port_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
      rdy_q      <= rdy_d;
      def_port_q <= def_port_d;
      def_drop_q <= def_drop_d;
    end
  end

  assign ready_o   = rdy_q;
  assign pkt_hdr_o = hdr_q;
  assign port_o    = port_q;
  assign drop_o    = drop_q;
  assign err_o     = err_q;
endmodule

// File: tb/tb_executor.sv
// Directed bench for executor: hand-computed headers, ports, flags and latencies.
module tb_executor;
  import exec_pkg::*;

  localparam int NA = VAL_LEN / 4;

  logic clk = 1'b0;
  logic rst;
  logic start_i, is_match_i, mod_start_i, mod_default_drop_i;
  logic [7:0] mod_default_port_i;
  logic [NA-1:0][31:0] flow_w;
  logic [HDR_LEN-1:0][BYTE_W-1:0] pkt_hdr_i, pkt_hdr_o, base_hdr, exp_hdr;
  logic [NUM_HDRS-1:0][DATA_W-1:0] parsed;
  logic ready_o, drop_o, err_o;
  logic [7:0] port_o;

  int checks = 0;
  int passed = 0;
  int lat;

  always #5 clk = ~clk;

  executor dut (
    .clk(clk), .rst(rst), .start_i(start_i), .is_match_i(is_match_i),
    .flow_val_i(flow_w), .pkt_hdr_i(pkt_hdr_i), .parsed_hdrs_i(parsed),
    .mod_start_i(mod_start_i), .mod_default_port_i(mod_default_port_i),
    .mod_default_drop_i(mod_default_drop_i), .ready_o(ready_o),
    .pkt_hdr_o(pkt_hdr_o), .port_o(port_o), .drop_o(drop_o), .err_o(err_o)
  );

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] hid,
                                     input logic [7:0] off, input logic [7:0] arg);
    return {arg, off, hid, op};
  endfunction

  // Presents a packet, counts edges from the accepting edge until ready_o (bounded).
  task automatic run_pkt(input logic m, input logic hold, output int n_out);
    @(negedge clk);
    is_match_i = m;
    start_i = 1'b1;
    n_out = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (!hold) start_i = 1'b0;
      if (ready_o === 1'b1) begin
        n_out = n;
        break;
      end
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready_o); else passed++;
    checks++; if (drop_o !== 1'b0) $display("FAIL reset_drop: got %b want 0", drop_o); else passed++;
    checks++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else passed++;
    checks++; if (port_o !== 8'd0) $display("FAIL reset_port: got %0d want 0", port_o); else passed++;
    checks++; if (pkt_hdr_o !== '0) $display("FAIL reset_hdr: got %h want 0", pkt_hdr_o); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_hit(input string tag);
    pkt_hdr_i = base_hdr;
    parsed = '0;
    parsed[0] = 32'd14;
    flow_w = '0;
    flow_w[0] = mk(8'd1, 8'd0, 8'd2, 8'hAB);
    flow_w[1] = mk(8'd4, 8'd0, 8'd0, 8'd5);
    flow_w[2] = mk(8'd0, 8'd0, 8'd0, 8'd0);
    flow_w[3] = mk(8'd4, 8'd0, 8'd0, 8'd9);
    exp_hdr = base_hdr;
    exp_hdr[16] = 8'hAB;
    run_pkt(1'b1, 1'b1, lat);
    checks++; if (lat !== 4) $display("FAIL %s_latency: got %0d want 4", tag, lat); else passed++;
    checks++; if (pkt_hdr_o !== exp_hdr) $display("FAIL %s_hdr: got %h want %h", tag, pkt_hdr_o, exp_hdr); else passed++;
    checks++; if (port_o !== 8'd5) $display("FAIL %s_port: got %0d want 5", tag, port_o); else passed++;
    checks++; if (drop_o !== 1'b0) $display("FAIL %s_drop: got %b want 0", tag, drop_o); else passed++;
    checks++; if (err_o !== 1'b0) $display("FAIL %s_err: got %b want 0", tag, err_o); else passed++;
  endtask

  task automatic test_config_miss();
    @(negedge clk);
    mod_start_i = 1'b1;
    mod_default_port_i = 8'd7;
    mod_default_drop_i = 1'b1;
    is_match_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (ready_o !== 1'b1) $display("FAIL mod_priority_ready: got %b want 1", ready_o); else passed++;
    mod_start_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    pkt_hdr_i = base_hdr;
    flow_w[0] = mk(8'd1, 8'd0, 8'd0, 8'hEE);
    flow_w[1] = mk(8'd4, 8'd0, 8'd0, 8'd9);
    flow_w[2] = mk(8'd0, 8'd0, 8'd0, 8'd0);
    run_pkt(1'b0, 1'b1, lat);
    checks++; if (lat !== 2) $display("FAIL miss_latency: got %0d want 2", lat); else passed++;
    checks++; if (port_o !== 8'd7) $display("FAIL miss_port: got %0d want 7", port_o); else passed++;
    checks++; if (drop_o !== 1'b1) $display("FAIL miss_drop: got %b want 1", drop_o); else passed++;
    checks++; if (pkt_hdr_o !== base_hdr) $display("FAIL miss_hdr: got %h want %h", pkt_hdr_o, base_hdr); else passed++;
  endtask

  task automatic test_add();
    pkt_hdr_i = base_hdr;
    pkt_hdr_i[7] = 8'hF8;
    parsed[1] = 32'd4;
    flow_w = '0;
    flow_w[0] = mk(8'd2, 8'd1, 8'd3, 8'h10);
    exp_hdr = pkt_hdr_i;
`ifdef EXECUTOR_ADD_EN
    exp_hdr[7] = 8'h08;
`endif
    run_pkt(1'b1, 1'b1, lat);
    checks++; if (lat !== 3) $display("FAIL add_latency: got %0d want 3", lat); else passed++;
    checks++; if (pkt_hdr_o !== exp_hdr) $display("FAIL add_hdr: got %h want %h", pkt_hdr_o, exp_hdr); else passed++;
    checks++; if (drop_o !== 1'b0) $display("FAIL add_drop: got %b want 0", drop_o); else passed++;
    checks++; if (port_o !== 8'd7) $display("FAIL add_port: got %0d want 7", port_o); else passed++;
  endtask

  task automatic test_err();
    pkt_hdr_i = base_hdr;
    parsed[2] = 32'd30;
    flow_w = '0;
    flow_w[0] = mk(8'd1, 8'd2, 8'd2, 8'h55);
    flow_w[1] = mk(8'd4, 8'd0, 8'd0, 8'd3);
    run_pkt(1'b1, 1'b1, lat);
    checks++; if (lat !== 4) $display("FAIL err_latency: got %0d want 4", lat); else passed++;
    checks++; if (err_o !== 1'b1) $display("FAIL err_flag: got %b want 1", err_o); else passed++;
    checks++; if (pkt_hdr_o !== base_hdr) $display("FAIL err_hdr: got %h want %h", pkt_hdr_o, base_hdr); else passed++;
    checks++; if (port_o !== 8'd3) $display("FAIL err_port: got %0d want 3", port_o); else passed++;
  endtask

  task automatic test_all_fwd();
    pkt_hdr_i = base_hdr;
    for (int k = 0; k < NA; k++) flow_w[k] = mk(8'd4, 8'd0, 8'd0, 8'(k + 1));
    run_pkt(1'b1, 1'b0, lat);
    checks++; if (lat !== 1 + NA) $display("FAIL fwd_latency: got %0d want %0d", lat, 1 + NA); else passed++;
    checks++; if (port_o !== 8'(NA)) $display("FAIL fwd_port: got %0d want %0d", port_o, NA); else passed++;
    checks++; if (err_o !== 1'b0) $display("FAIL fwd_err: got %b want 0", err_o); else passed++;
  endtask

  task automatic test_drop();
    pkt_hdr_i = base_hdr;
    parsed[3] = 32'd0;
    flow_w = '0;
    flow_w[0] = mk(8'd1, 8'd3, 8'd0, 8'h11);
    flow_w[1] = mk(8'd3, 8'd0, 8'd0, 8'd0);
    exp_hdr = base_hdr;
    exp_hdr[0] = 8'h11;
    run_pkt(1'b1, 1'b1, lat);
    checks++; if (lat !== 4) $display("FAIL drop_latency: got %0d want 4", lat); else passed++;
    checks++; if (drop_o !== 1'b1) $display("FAIL drop_flag: got %b want 1", drop_o); else passed++;
    checks++; if (pkt_hdr_o !== exp_hdr) $display("FAIL drop_hdr: got %h want %h", pkt_hdr_o, exp_hdr); else passed++;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < NA; k++) flow_w[k] = mk(8'd4, 8'd0, 8'd0, 8'(k + 1));
    @(negedge clk);
    is_match_i = 1'b1;
    start_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (ready_o !== 1'b0) $display("FAIL rstmid_ready: got %b want 0", ready_o); else passed++;
    checks++; if (port_o !== 8'd0) $display("FAIL rstmid_port: got %0d want 0", port_o); else passed++;
    checks++; if (drop_o !== 1'b0) $display("FAIL rstmid_drop: got %b want 0", drop_o); else passed++;
    checks++; if (pkt_hdr_o !== '0) $display("FAIL rstmid_hdr: got %h want 0", pkt_hdr_o); else passed++;
    start_i = 1'b0;
    rst = 1'b0;
    test_hit("after_rst");
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    is_match_i = 1'b0;
    mod_start_i = 1'b0;
    mod_default_port_i = 8'd0;
    mod_default_drop_i = 1'b0;
    flow_w = '0;
    parsed = '0;
    for (int i = 0; i < HDR_LEN; i++) base_hdr[i] = 8'(8'h40 + i);
    pkt_hdr_i = base_hdr;
    exp_hdr = base_hdr;
    test_reset();
    test_hit("hit");
    test_config_miss();
    test_add();
    test_err();
    test_all_fwd();
    test_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/executor.md
EXECUTOR -- requirements
Module: executor

Interface
REQ-001 Parameter NUM_ACTIONS, default `MAX_VAL_LEN/4, number of 4-byte action slots in flow_val_i.
REQ-002 Reset rst, synchronous, active-high; clock clk.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start_i  in  1  level request from matcher ready_o; held until ready_o seen.
REQ-006 is_match_i  in  1  matcher hit flag, sampled with start_i.
REQ-007 flow_val_i  in  `BYTE_BUS x `MAX_VAL_LEN  action list, sampled with start_i.
REQ-008 pkt_hdr_i  in  `BYTE_BUS x `HDR_MAX_LEN  packet header bytes.
REQ-009 parsed_hdrs_i  in  `DATA_BUS x `NUM_HEADERS  header start offsets.
REQ-010 mod_start_i  in  1  table-config write strobe; mod_default_port_i (8) default egress port; mod_default_drop_i (1) drop on miss.
REQ-011 ready_o  out  1  result valid; pkt_hdr_o (`BYTE_BUS x `HDR_MAX_LEN) edited header; port_o (8) egress port; drop_o (1) drop flag; err_o (1) out-of-range action seen.

Function
REQ-012 Action slot k = flow_val_i[4k..4k+3] = {opcode, hdr_id[3:0], off, arg}; opcodes: 0 END, 1 SET, 2 ADD, 3 DROP, 4 FWD, others NOP.
REQ-013 States FREE, EXEC, DONE; FREE->EXEC on start_i & !mod_start_i; EXEC->DONE after last action; DONE->FREE when start_i low.
REQ-014 In FREE, mod_start_i takes priority over start_i and latches default port/drop; no packet accepted that cycle.
REQ-015 On accept: latch flow_val_i, is_match_i; copy pkt_hdr_i to working header; clear ready_o, drop_o, err_o; port_o <= default port; slot counter <= 0.
REQ-016 Miss (is_match_i=0): EXEC applies no actions; drop_o <= default drop; DONE next cycle.
REQ-017 Hit: exactly one slot per EXEC cycle, in index order.
REQ-018 Target byte index = parsed_hdrs_i[hdr_id] + off, 32-bit unsigned; index >= `HDR_MAX_LEN -> action ignored, err_o <= 1, execution continues.
REQ-019 SET writes arg to target; ADD writes (target + arg) mod 256; DROP sets drop_o; FWD sets port_o <= arg; later FWD overrides earlier.
REQ-020 END or slot NUM_ACTIONS-1 executed -> DONE; END itself has no effect.
REQ-021 On EXEC->DONE: pkt_hdr_o <= working header, ready_o <= 1; hit latency = 1 + executed slots (incl. END) cycles from accept to ready_o; miss latency 2.
REQ-022 Outputs stable throughout DONE; ready_o cleared on next accept only.
REQ-023 start_i dropped mid-EXEC is ignored; execution completes, DONE exits immediately after.

Reset
REQ-024 rst: state FREE, ready_o 0, drop_o 0, err_o 0, port_o 0, pkt_hdr_o all 0, defaults 0, slot counter 0.
REQ-025 rst mid-EXEC aborts packet; no partial result visible; ready_o 0.

Configuration
REQ-026 Macro EXECUTOR_ADD_EN: defined -> ADD per REQ-019; undefined -> opcode 2 is NOP, ADD adder logic absent.

Structure
REQ-027 Opcode enum and slot field widths in shared package exec_pkg; sizes stay in def.svh.
REQ-028 Sub-module action_alu: combinational, one slot + target byte in, new byte/drop/port/err out.

Verification
REQ-029 Hit, slots {SET h0 off2 0xAB, FWD 0 0 5, END}, parsed_hdrs[0]=14 -> byte16=0xAB, port_o=5, drop_o=0, ready_o 4 cycles after accept.
REQ-030 Miss with default port 7, drop 1 -> port_o=7, drop_o=1, header unchanged, ready_o 2 cycles after accept.
REQ-031 ADD 0x10 to byte 0xF8 -> 0x08 with EXECUTOR_ADD_EN; byte unchanged without.
REQ-032 SET with parsed offset+off = `HDR_MAX_LEN -> err_o=1, header unchanged, following FWD 3 still applied.
REQ-033 All NUM_ACTIONS slots FWD 1..NUM_ACTIONS, no END -> port_o=NUM_ACTIONS, ready_o 1+NUM_ACTIONS cycles after accept.
REQ-034 rst asserted in EXEC then start_i reapplied -> outputs zero during reset, fresh packet processed correctly.
